// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//  Bundles the core-side request/ack signals and the single-ported memory bus
//  that mem_arbiter sits between.
//  Ports (signals):
//   if_req/if_addr/if_rdata/if_ack          instruction-fetch requester
//   d_req/d_wr/d_addr/d_wdata/d_rdata/d_ack  load/store requester
//   stall                                    PC hold request to the core
//   mem_enable/mem_wr/mem_addr/mem_wdata     memory issue bus
//   mem_rdata                                memory read data (one cycle after issue)
//  Modports:
//   slave  - the arbiter's view
//   master - the environment's view (core + memory)
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          stall;
  logic          mem_enable;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, stall,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, stall,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//  Shares one single-ported memory between the instruction-fetch port and the
//  load/store data port. Each access is issued in one cycle (combinational
//  from the granted port) and acknowledged in the next, so a new grant is
//  possible every second cycle. Data wins over fetch unless fetch has been
//  passed over STARVE_LIMIT times in a row.
//  Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave (requester ports, stall, memory bus)
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT} state_t;

  state_t        state_reg;
  logic [CW-1:0] starve_cnt_reg;
  logic [DW-1:0] if_hold_reg;
  logic [DW-1:0] d_hold_reg;
  logic          d_load_reg;   // access in D_WAIT is a load (captures read data)

  logic issue_ok;
  logic starved;
  logic grant_if;
  logic grant_d;

  // Issue only from IDLE; reset suppresses any issue in the same cycle.
  assign issue_ok = (state_reg == IDLE) && !rst;
  assign starved  = (starve_cnt_reg == CW'(STARVE_LIMIT));
  assign grant_if = issue_ok && bus.if_req && (!bus.d_req || starved);
  assign grant_d  = issue_ok && bus.d_req && !grant_if;

  // Memory bus: driven from the granted port in the issue cycle, zero otherwise.
  assign bus.mem_enable = grant_if || grant_d;
  assign bus.mem_wr     = grant_d && bus.d_wr;
  assign bus.mem_addr   = grant_d  ? bus.d_addr :
                          grant_if ? bus.if_addr : '0;
  assign bus.mem_wdata  = grant_d ? bus.d_wdata : '0;

  // Acks come from registered state; reset in the wait cycle drops the access.
  assign bus.if_ack   = (state_reg == IF_WAIT) && !rst;
  assign bus.d_ack    = (state_reg == D_WAIT) && !rst;
  assign bus.if_rdata = bus.if_ack ? bus.mem_rdata : if_hold_reg;
  assign bus.d_rdata  = (bus.d_ack && d_load_reg) ? bus.mem_rdata : d_hold_reg;
  assign bus.stall    = bus.if_req && !bus.if_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      if_hold_reg    <= '0;
      d_hold_reg     <= '0;
      d_load_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_if) begin
            state_reg <= IF_WAIT;
          end else if (grant_d) begin
            state_reg  <= D_WAIT;
            d_load_reg <= !bus.d_wr;
          end
        end
        IF_WAIT: begin
          if_hold_reg <= bus.mem_rdata;
          state_reg   <= IDLE;
        end
        D_WAIT: begin
          if (d_load_reg) begin
            d_hold_reg <= bus.mem_rdata;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // Counts data grants that overtook a waiting fetch; saturates so the
      // starved comparison stays true until fetch is finally granted.
      if (!bus.if_req || grant_if) begin
        starve_cnt_reg <= '0;
      end else if (grant_d && !starved) begin
        starve_cnt_reg <= starve_cnt_reg + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: registered read, write committed at the issue edge.
  logic [31:0] init_val [256];
  logic [31:0] env_mem  [256];
  logic        written  [256];
  logic [31:0] env_rd = '0;

  always @(posedge clk) begin
    if (bus.mem_enable) begin
      if (bus.mem_wr) begin
        env_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        written[bus.mem_addr[9:2]] <= 1'b1;
      end else begin
        env_rd <= (written[bus.mem_addr[9:2]] === 1'b1) ? env_mem[bus.mem_addr[9:2]]
                                                         : init_val[bus.mem_addr[9:2]];
      end
    end
  end
  assign bus.mem_rdata = env_rd;

  // Transaction-level reference: what was issued last cycle, the expected data
  // for it, the streak of data grants that overtook a waiting fetch, and a
  // golden copy of memory contents.
  logic [31:0] gold [256];
  int          m_issued = 0;  // 0 none, 1 fetch, 2 load, 3 store
  logic [31:0] m_data   = '0;
  int          m_streak = 0;
  logic [31:0] m_if_hold = '0;
  logic [31:0] m_d_hold  = '0;

  logic [31:0] obs_if_rdata, obs_d_rdata;
  logic        obs_if_ack, obs_d_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check all outputs against the reference mid-cycle, then
  // advance the reference across the edge. Inputs are changed by the caller
  // just after the edge.
  task automatic step();
    logic [31:0] e_en, e_wr, e_addr, e_wd, e_ia, e_da, e_ir, e_dr, e_st;
    int          n_issued, n_streak;
    logic [31:0] n_data, n_ih, n_dh;
    bit          st_commit;
    logic [7:0]  st_idx;
    logic [31:0] st_val;
    @(negedge clk);
    obs_if_rdata = bus.if_rdata;
    obs_d_rdata  = bus.d_rdata;
    obs_if_ack   = bus.if_ack;
    obs_d_ack    = bus.d_ack;
    e_en = 0; e_wr = 0; e_addr = 0; e_wd = 0; e_ia = 0; e_da = 0;
    e_ir = m_if_hold; e_dr = m_d_hold;
    n_issued = 0; n_data = m_data; n_ih = m_if_hold; n_dh = m_d_hold;
    n_streak = bus.if_req ? m_streak : 0;
    st_commit = 0; st_idx = '0; st_val = '0;
    if (rst) begin
      n_ih = '0; n_dh = '0; n_streak = 0;
    end else if (m_issued == 1) begin
      e_ia = 1; e_ir = m_data; n_ih = m_data;
    end else if (m_issued >= 2) begin
      e_da = 1;
      if (m_issued == 2) begin
        e_dr = m_data; n_dh = m_data;
      end
    end else if (bus.if_req && (!bus.d_req || m_streak == LIMIT)) begin
      e_en = 1; e_addr = bus.if_addr;
      n_issued = 1; n_data = gold[bus.if_addr[9:2]]; n_streak = 0;
    end else if (bus.d_req) begin
      e_en = 1; e_wr = bus.d_wr; e_addr = bus.d_addr; e_wd = bus.d_wdata;
      n_issued = bus.d_wr ? 3 : 2;
      n_data = gold[bus.d_addr[9:2]];
      if (bus.if_req) n_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
      if (bus.d_wr) begin
        st_commit = 1; st_idx = bus.d_addr[9:2]; st_val = bus.d_wdata;
      end
    end
    e_st = (bus.if_req && e_ia == 0) ? 1 : 0;
    chk("mem_enable", bus.mem_enable, e_en);
    chk("mem_wr", bus.mem_wr, e_wr);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wd);
    chk("if_ack", bus.if_ack, e_ia);
    chk("d_ack", bus.d_ack, e_da);
    chk("if_rdata", bus.if_rdata, e_ir);
    chk("d_rdata", bus.d_rdata, e_dr);
    chk("stall", bus.stall, e_st);
    @(posedge clk);
    m_issued = n_issued; m_data = n_data; m_streak = n_streak;
    m_if_hold = n_ih; m_d_hold = n_dh;
    if (st_commit) gold[st_idx] = st_val;
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    return a;
  endfunction

  initial begin
    int d_before_if;
    bit seen_if;
    int if_wait, d_wait;
    logic [31:0] v;

    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      if (i == 4) v = 32'h0050_0093;
      init_val[i] = v;
      gold[i]     = v;
      written[i]  = 1'b0;
    end

    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0;
    step(); step();
    rst = 1'b0;
    step();

    // Fetch only from 0x10
    bus.if_req = 1; bus.if_addr = 32'h10;
    step();
    step();
    chk("fetch_data", obs_if_rdata, 32'h0050_0093);
    chk("fetch_ack", obs_if_ack, 1);
    bus.if_req = 0;
    step();

    // Store then chained load from 0x100
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
    step(); step();
    bus.d_wr = 0;
    step(); step();
    chk("load_data", obs_d_rdata, 32'hDEAD_BEEF);
    bus.d_req = 0;
    step();
    chk("load_hold", obs_d_rdata, 32'hDEAD_BEEF);

    // Contention: data first, then fetch
    bus.if_req = 1; bus.if_addr = 32'h20;
    bus.d_req = 1; bus.d_addr = 32'h40;
    step(); step();
    bus.d_req = 0;
    step(); step();
    chk("contend_if_ack", obs_if_ack, 1);
    bus.if_req = 0;
    step();

    // Starvation: exactly LIMIT data acks before the fetch ack
    bus.if_req = 1; bus.if_addr = 32'h30;
    bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h80;
    d_before_if = 0; seen_if = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (obs_if_ack) begin
        seen_if = 1;
        bus.if_req = 0;
      end
      if (obs_d_ack && !seen_if) d_before_if++;
    end
    chk("starve_seen_fetch", 32'(seen_if), 1);
    chk("starve_data_grants", d_before_if, LIMIT);
    bus.d_req = 0;
    step();
    // Streak cleared: contention again gives data first
    bus.if_req = 1; bus.d_req = 1;
    step(); step();
    chk("post_starve_data_first", obs_d_ack, 1);
    bus.d_req = 0;
    step(); step();
    bus.if_req = 0;
    step();

    // Reset in D_WAIT of a load
    bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h100;
    step();
    rst = 1;
    step();
    chk("rst_no_dack", obs_d_ack, 0);
    rst = 0;
    step();
    chk("rst_drdata_zero", obs_d_rdata, 0);
    step();
    chk("rst_new_load", obs_d_rdata, 32'hDEAD_BEEF);
    bus.d_req = 0;
    step();

    // Chained fetch 0x0/0x4/0x8
    bus.if_req = 1;
    for (int k = 0; k < 3; k++) begin
      bus.if_addr = 32'(k * 4);
      step(); step();
      chk("chain_ack", obs_if_ack, 1);
      chk("chain_data", obs_if_rdata, init_val[k]);
    end
    bus.if_req = 0;
    step();

    // Randomised traffic with occasional reset
    if_wait = 0; d_wait = 0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      step();
      if (obs_if_ack || !bus.if_req) begin
        if_wait = 0;
        if ($urandom_range(0, 2) != 0) begin
          bus.if_req = 1; bus.if_addr = rnd_addr();
        end else begin
          bus.if_req = 0;
        end
      end else begin
        if_wait++;
      end
      if (obs_d_ack || !bus.d_req) begin
        d_wait = 0;
        if ($urandom_range(0, 2) != 0) begin
          bus.d_req = 1; bus.d_wr = $urandom_range(0, 1);
          bus.d_addr = rnd_addr(); bus.d_wdata = $urandom;
        end else begin
          bus.d_req = 0;
        end
      end else begin
        d_wait++;
      end
      chk("if_wait_bound", 32'(if_wait > 20), 0);
      chk("d_wait_bound", 32'(d_wait > 20), 0);
      if (if_wait > 20) begin
        bus.if_req = 0; if_wait = 0;
      end
      if (d_wait > 20) begin
        bus.d_req = 0; d_wait = 0;
      end
    end
    rst = 0; bus.if_req = 0; bus.d_req = 0;
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
